// File: rtl/multibyte_add_seq.sv
// Sequential multi-byte adder controller. Adds two NBYTES-wide unsigned
// operands through one shared external 8-bit adder, one byte per cycle,
// least-significant byte first, chaining the carry in a register.
//
// Handshake: a request is taken on any rising edge where start=1 and the
// controller is in IDLE or DONE; operands and carry_in are sampled on that
// edge. start is ignored (not queued) while busy=1. done is a one-cycle
// pulse during which result/overflow are valid; both then hold until the
// next accepted request.
module multibyte_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   op_a,
    input  logic [8*NBYTES-1:0]   op_b,
    input  logic                  carry_in,
    output logic [7:0]            add_a,
    output logic [7:0]            add_b,
    output logic                  add_cin,
    input  logic [7:0]            add_sum,
    input  logic                  add_cout,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  overflow,
    output logic [1:0]            dbg_state
);

    localparam int W    = 8 * NBYTES;
    localparam int IDXW = $clog2(NBYTES);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    result_q, result_d;
    logic            ovf_q, ovf_d;

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    // Next-state logic and adder drive; the adder is idle (all zero) outside ADD.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        add_a    = 8'd0;
        add_b    = 8'd0;
        add_cin  = 1'b0;

        case (state_q)
            S_ADD: begin
                add_a   = a_q[8*idx_q +: 8];
                add_b   = b_q[8*idx_q +: 8];
                add_cin = carry_q;
                result_d[8*idx_q +: 8] = add_sum;
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    ovf_d   = add_cout;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            S_IDLE, S_DONE: begin
                if (start) begin
                    // Result is left stale; only overflow is cleared on accept.
                    a_d     = op_a;
                    b_d     = op_b;
                    carry_d = carry_in;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_ADD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy      = (state_q == S_ADD);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign dbg_state = state_q;

endmodule
